// File: rtl/sr_pkg.sv
// Shared types for the SR command sequencer.
//   state_t : sequencer FSM state (IDLE -> DRIVE -> GAP -> IDLE)
//   cmd_t   : command kind carried through arbitration and the pending slot
//   arbitrate() : picks the surviving command when set/clear events coincide
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef enum logic {
    CMD_SET = 1'b0,
    CMD_CLR = 1'b1
  } cmd_t;

  // Only meaningful when at least one event is present; with a single event
  // that event's command is returned, with both the priority input decides.
  function automatic cmd_t arbitrate(input logic set_evt,
                                     input logic clr_evt,
                                     input logic set_wins);
    cmd_t c;
    if (set_evt && clr_evt) begin
      c = set_wins ? CMD_SET : CMD_CLR;
    end else if (set_evt) begin
      c = CMD_SET;
    end else begin
      c = CMD_CLR;
    end
    return c;
  endfunction

endpackage

// File: rtl/sr_cmd_sequencer_if.sv
// Signal bundle between the request source / SR stage and the sequencer.
//   set_in, clr_in : raw asynchronous requests (driven by master)
//   s, r           : registered drives to the SR stage
//   busy           : sequencer not idle
//   shadow_q       : value the SR stage is expected to hold
//   conflict       : one-cycle flag, set and clear events coincided
//   overrun        : one-cycle flag, pending slot overwritten
//   conflict_cnt   : saturating conflict counter
interface sr_cmd_sequencer_if #(
  parameter int CNT_W = 8
) ();

  logic             set_in;
  logic             clr_in;
  logic             s;
  logic             r;
  logic             busy;
  logic             shadow_q;
  logic             conflict;
  logic             overrun;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output set_in, clr_in,
    input  s, r, busy, shadow_q, conflict, overrun, conflict_cnt
  );

  modport slave (
    input  set_in, clr_in,
    output s, r, busy, shadow_q, conflict, overrun, conflict_cnt
  );

endinterface

// File: rtl/sr_debounce.sv
// Input conditioning for one raw request line.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : raw asynchronous request
//   rise       : one-cycle registered pulse on a rising edge of the
//                debounced level
// The debounced level flips only after the synchronised input has disagreed
// with it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts
// the count.
module sr_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DB_W-1:0]        cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   db_dly_q;
  logic                   rise_q, rise_d;
  logic                   synced;

  assign sync_d[0] = din;
  for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
    assign sync_d[gi] = sync_q[gi-1];
  end

  assign synced = sync_q[SYNC_STAGES-1];

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (synced != db_q) begin
      if (cnt_q == DB_LAST) begin
        db_d = ~db_q;
      end else begin
        cnt_d = cnt_q + DB_W'(1);
      end
    end
    // Registered edge detect: the event appears the cycle after the level flips.
    rise_d = db_q & ~db_dly_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
      rise_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_q;
      rise_q   <= rise_d;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Upstream driver for an SR flip-flop stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of sr_cmd_sequencer_if (raw requests in; s/r
//                drives, busy, shadow, conflict/overrun flags and the
//                saturating conflict counter out)
// Raw set/clear requests are synchronised and debounced, their rising edges
// become events, simultaneous events are arbitrated, and the winner is issued
// as a PULSE_CYCLES-wide pulse on s or r followed by GAP_CYCLES of quiet.
// One pending slot absorbs an event arriving while a command is in flight.
module sr_cmd_sequencer
  import sr_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1,
  parameter int GAP_CYCLES      = 1,
  parameter int SET_PRIORITY    = 1,
  parameter int CNT_W           = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sr_cmd_sequencer_if.slave   bus
);

  localparam int PH_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PH_W-1:0] PULSE_LAST = PH_W'(PULSE_CYCLES - 1);
  localparam logic [PH_W-1:0] GAP_LAST   = PH_W'(GAP_CYCLES - 1);
  localparam logic            SET_WINS   = (SET_PRIORITY != 0);

  // Index 0 carries the set request, index 1 the clear request.
  logic [1:0] raw_in;
  logic [1:0] evt;
  logic       set_evt, clr_evt, any_evt;
  cmd_t       win_cmd;

  assign raw_in = {bus.clr_in, bus.set_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_db
    sr_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (raw_in[gi]),
      .rise  (evt[gi])
    );
  end

  assign set_evt = evt[0];
  assign clr_evt = evt[1];
  assign any_evt = set_evt | clr_evt;
  assign win_cmd = arbitrate(set_evt, clr_evt, SET_WINS);

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
  cmd_t             cmd_q, cmd_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             shadow_q, shadow_d;
  logic             pend_valid_q, pend_valid_d;
  cmd_t             pend_cmd_q, pend_cmd_d;
  logic             conflict_q, conflict_d;
  logic             overrun_q, overrun_d;
  logic [CNT_W-1:0] conflict_cnt_q, conflict_cnt_d;
  logic             launch;
  cmd_t             launch_cmd;

  always_comb begin
    state_d        = state_q;
    ph_cnt_d       = ph_cnt_q;
    cmd_d          = cmd_q;
    shadow_d       = shadow_q;
    pend_valid_d   = pend_valid_q;
    pend_cmd_d     = pend_cmd_q;
    s_d            = 1'b0;
    r_d            = 1'b0;
    overrun_d      = 1'b0;
    launch         = 1'b0;
    launch_cmd     = CMD_SET;
    conflict_d     = set_evt & clr_evt;
    conflict_cnt_d = conflict_cnt_q;
    if (conflict_d && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          // The older pending command goes first; a same-cycle event takes
          // the freed slot without counting as an overrun.
          launch     = 1'b1;
          launch_cmd = pend_cmd_q;
          pend_valid_d = any_evt;
          if (any_evt) begin
            pend_cmd_d = win_cmd;
          end
        end else if (any_evt) begin
          launch     = 1'b1;
          launch_cmd = win_cmd;
        end
      end
      DRIVE: begin
        if (ph_cnt_q == PULSE_LAST) begin
          state_d  = GAP;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
          s_d      = (cmd_q == CMD_SET);
          r_d      = (cmd_q == CMD_CLR);
        end
      end
      GAP: begin
        if (ph_cnt_q == GAP_LAST) begin
          state_d  = IDLE;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        ph_cnt_d = '0;
      end
    endcase

    // While a command is in flight the winner is parked; latest event wins.
    if ((state_q != IDLE) && any_evt) begin
      pend_valid_d = 1'b1;
      pend_cmd_d   = win_cmd;
      overrun_d    = pend_valid_q;
    end

    if (launch) begin
      state_d  = DRIVE;
      ph_cnt_d = '0;
      cmd_d    = launch_cmd;
      s_d      = (launch_cmd == CMD_SET);
      r_d      = (launch_cmd == CMD_CLR);
      shadow_d = (launch_cmd == CMD_SET);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      ph_cnt_q       <= '0;
      cmd_q          <= CMD_SET;
      s_q            <= 1'b0;
      r_q            <= 1'b0;
      shadow_q       <= 1'b0;
      pend_valid_q   <= 1'b0;
      pend_cmd_q     <= CMD_SET;
      conflict_q     <= 1'b0;
      overrun_q      <= 1'b0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      ph_cnt_q       <= ph_cnt_d;
      cmd_q          <= cmd_d;
      s_q            <= s_d;
      r_q            <= r_d;
      shadow_q       <= shadow_d;
      pend_valid_q   <= pend_valid_d;
      pend_cmd_q     <= pend_cmd_d;
      conflict_q     <= conflict_d;
      overrun_q      <= overrun_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign bus.s            = s_q;
  assign bus.r            = r_q;
  assign bus.busy         = (state_q != IDLE);
  assign bus.shadow_q     = shadow_q;
  assign bus.conflict     = conflict_q;
  assign bus.overrun      = overrun_q;
  assign bus.conflict_cnt = conflict_cnt_q;

endmodule
